// File: rtl/y86_pkg.sv
// Shared Y86-64 execute-stage definitions: instruction codes, ALU functions,
// branch conditions, sequencer states and the condition-code register.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_CMOVXX = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] IFUN_MAX_OP   = 4'h3;
  localparam logic [3:0] IFUN_MAX_COND = 4'h6;

  localparam logic [63:0] STACK_DEC = 64'hFFFF_FFFF_FFFF_FFF8;
  localparam logic [63:0] STACK_INC = 64'h0000_0000_0000_0008;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_XOR = 2'd3
  } alu_fun_e;

  typedef enum logic [3:0] {
    C_ALWAYS = 4'd0,
    C_LE     = 4'd1,
    C_L      = 4'd2,
    C_E      = 4'd3,
    C_NE     = 4'd4,
    C_GE     = 4'd5,
    C_G      = 4'd6
  } cond_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } cc_t;

  localparam cc_t CC_RESET = '{zf: 1'b1, sf: 1'b0, of: 1'b0};

  function automatic logic cond_holds(cc_t cc, logic [3:0] ifun);
    logic lt;
    lt = cc.sf ^ cc.of;
    case (cond_e'(ifun))
      C_ALWAYS: cond_holds = 1'b1;
      C_LE:     cond_holds = lt | cc.zf;
      C_L:      cond_holds = lt;
      C_E:      cond_holds = cc.zf;
      C_NE:     cond_holds = ~cc.zf;
      C_GE:     cond_holds = ~lt;
      C_G:      cond_holds = ~lt & ~cc.zf;
      default:  cond_holds = 1'b0;
    endcase
  endfunction

  function automatic logic is_illegal(logic [3:0] icode, logic [3:0] ifun);
    is_illegal = (icode > I_POPQ) ||
                 (icode == I_OPQ && ifun > IFUN_MAX_OP) ||
                 ((icode == I_CMOVXX || icode == I_JXX) && ifun > IFUN_MAX_COND);
  endfunction

endpackage

// File: rtl/alu_64.sv
// Combinational 64-bit Y86 ALU producing a result and its ZF/SF/OF flags.
module alu_64
  import y86_pkg::*;
(
  input  logic [63:0] alu_a,
  input  logic [63:0] alu_b,
  input  alu_fun_e    fun,
  output logic [63:0] result,
  output logic        zf,
  output logic        sf,
  output logic        of
);

  // Subtraction is aluB - aluA, so overflow is judged against aluB's sign.
  always_comb begin
    result = '0;
    of     = 1'b0;
    case (fun)
      ALU_ADD: begin
        result = alu_b + alu_a;
        of     = (alu_a[63] == alu_b[63]) && (result[63] != alu_a[63]);
      end
      ALU_SUB: begin
        result = alu_b - alu_a;
        of     = (alu_a[63] != alu_b[63]) && (result[63] != alu_b[63]);
      end
      ALU_AND: result = alu_b & alu_a;
      ALU_XOR: result = alu_b ^ alu_a;
    endcase
  end

  assign zf = (result == '0);
  assign sf = result[63];

endmodule

// File: rtl/exec_sequencer.sv
// Y86-64 execute stage wrapped in an IDLE -> EXEC -> DONE handshake sequencer
// that owns the condition-code register.
module exec_sequencer #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_icode,
  input  logic [3:0]        in_ifun,
  input  logic [DATA_W-1:0] in_valA,
  input  logic [DATA_W-1:0] in_valB,
  input  logic [DATA_W-1:0] in_valC,
  input  logic              in_cc_inhibit,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_valE,
  output logic              out_cnd,
  output logic [2:0]        out_cc,
  output logic              out_err
);
  import y86_pkg::*;

  state_e            state_q, state_d;
  logic [3:0]        icode_q, icode_d, ifun_q, ifun_d;
  logic [DATA_W-1:0] val_a_q, val_a_d, val_b_q, val_b_d, val_c_q, val_c_d;
  logic [DATA_W-1:0] val_e_q, val_e_d;
  logic              inhibit_q, inhibit_d, cnd_q, cnd_d, err_q, err_d;
  cc_t               cc_q, cc_d;

  logic [DATA_W-1:0] alu_a, alu_b, alu_result;
  alu_fun_e          alu_fun;
  logic              alu_zf, alu_sf, alu_of;
  logic              illegal;

  // NOTE: every signal written in a combinational block gets a default first,
  // so no path through the case statements can infer a latch.
  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_fun = ALU_ADD;
    case (icode_q)
      I_CMOVXX, I_OPQ:              alu_a = val_a_q;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = val_c_q;
      I_CALL, I_PUSHQ:              alu_a = STACK_DEC;
      I_RET, I_POPQ:                alu_a = STACK_INC;
      default:                      alu_a = '0;
    endcase
    case (icode_q)
      I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: alu_b = val_b_q;
      default:                                                   alu_b = '0;
    endcase
    if (icode_q == I_OPQ && ifun_q <= IFUN_MAX_OP) alu_fun = alu_fun_e'(ifun_q[1:0]);
  end

  alu_64 u_alu (
    .alu_a  (alu_a),
    .alu_b  (alu_b),
    .fun    (alu_fun),
    .result (alu_result),
    .zf     (alu_zf),
    .sf     (alu_sf),
    .of     (alu_of)
  );

  assign illegal = is_illegal(icode_q, ifun_q);

  always_comb begin
    state_d   = state_q;
    icode_d   = icode_q;
    ifun_d    = ifun_q;
    val_a_d   = val_a_q;
    val_b_d   = val_b_q;
    val_c_d   = val_c_q;
    inhibit_d = inhibit_q;
    val_e_d   = val_e_q;
    cnd_d     = cnd_q;
    err_d     = err_q;
    cc_d      = cc_q;
    // Flush wins over everything except reset: it also blocks an IDLE handshake
    // and suppresses the EXEC-cycle CC write.
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            state_d   = S_EXEC;
            icode_d   = in_icode;
            ifun_d    = in_ifun;
            val_a_d   = in_valA;
            val_b_d   = in_valB;
            val_c_d   = in_valC;
            inhibit_d = in_cc_inhibit;
          end
        end
        S_EXEC: begin
          state_d = S_DONE;
          val_e_d = alu_result;
          err_d   = illegal;
          // Conditions read the CC as it stood before this instruction.
          cnd_d   = (icode_q == I_CMOVXX || icode_q == I_JXX) && cond_holds(cc_q, ifun_q);
          if (icode_q == I_OPQ && !illegal && !inhibit_q)
            cc_d = '{zf: alu_zf, sf: alu_sf, of: alu_of};
        end
        S_DONE: begin
          if (out_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values computed before this edge regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      icode_q   <= '0;
      ifun_q    <= '0;
      val_a_q   <= '0;
      val_b_q   <= '0;
      val_c_q   <= '0;
      inhibit_q <= 1'b0;
      val_e_q   <= '0;
      cnd_q     <= 1'b0;
      err_q     <= 1'b0;
      cc_q      <= CC_RESET;
    end else begin
      state_q   <= state_d;
      icode_q   <= icode_d;
      ifun_q    <= ifun_d;
      val_a_q   <= val_a_d;
      val_b_q   <= val_b_d;
      val_c_q   <= val_c_d;
      inhibit_q <= inhibit_d;
      val_e_q   <= val_e_d;
      cnd_q     <= cnd_d;
      err_q     <= err_d;
      cc_q      <= cc_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out_valE  = val_e_q;
  assign out_cnd   = cnd_q;
  assign out_err   = err_q;
  assign out_cc    = cc_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Randomised scoreboard bench for exec_sequencer with directed corner cases
// (overflow, je after sub, stack ops, backpressure, flush, reset mid-operation).
module tb_exec_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [3:0]  in_icode, in_ifun;
  logic [63:0] in_valA, in_valB, in_valC;
  logic        in_cc_inhibit, flush;
  logic        out_valid, out_ready;
  logic [63:0] out_valE;
  logic        out_cnd, out_err;
  logic [2:0]  out_cc;

  always #5 clk = ~clk;

  exec_sequencer #(.DATA_W(64)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_icode      (in_icode),
    .in_ifun       (in_ifun),
    .in_valA       (in_valA),
    .in_valB       (in_valB),
    .in_valC       (in_valC),
    .in_cc_inhibit (in_cc_inhibit),
    .flush         (flush),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_valE      (out_valE),
    .out_cnd       (out_cnd),
    .out_cc        (out_cc),
    .out_err       (out_err)
  );

  typedef struct packed {
    logic [63:0] val_e;
    logic        cnd;
    logic        err;
    logic [2:0]  cc;
  } exp_t;

  exp_t       exp_q[$];
  logic [2:0] model_cc;
  logic [2:0] prev_cc;
  int         n_checks = 0;
  int         n_err    = 0;
  bit         rand_mode   = 1'b0;
  bit         force_ready = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: Y86 execute semantics from signed/unsigned arithmetic.
  function automatic exp_t ref_model(input logic [3:0] icode, input logic [3:0] ifun,
                                     input logic [63:0] a, input logic [63:0] b,
                                     input logic [63:0] c, input logic inh,
                                     input logic [2:0] cc_in);
    exp_t        e;
    logic [64:0] wide;
    logic [63:0] r;
    logic        o, zf, sf, of;
    e   = '0;
    r   = '0;
    o   = 1'b0;
    e.err = (icode > 4'hB) || (icode == 4'h6 && ifun > 4'h3) ||
            ((icode == 4'h2 || icode == 4'h7) && ifun > 4'h6);
    case (icode)
      4'h2:        e.val_e = a;
      4'h3:        e.val_e = c;
      4'h4, 4'h5:  e.val_e = b + c;
      4'h8, 4'hA:  e.val_e = b - 64'd8;
      4'h9, 4'hB:  e.val_e = b + 64'd8;
      4'h6: begin
        case (ifun)
          4'h0: begin wide = {a[63], a} + {b[63], b}; r = wide[63:0]; o = wide[64] != wide[63]; end
          4'h1: begin wide = {b[63], b} - {a[63], a}; r = wide[63:0]; o = wide[64] != wide[63]; end
          4'h2: r = a & b;
          4'h3: r = a ^ b;
          default: r = a + b;
        endcase
        e.val_e = r;
      end
      default: e.val_e = 64'd0;
    endcase
    if (icode == 4'h6 && ifun <= 4'h3 && !inh) e.cc = {(r == 64'd0), r[63], o};
    else                                      e.cc = cc_in;
    zf = cc_in[2];
    sf = cc_in[1];
    of = cc_in[0];
    if (icode == 4'h2 || icode == 4'h7) begin
      case (ifun)
        4'h0: e.cnd = 1'b1;
        4'h1: e.cnd = (sf ^ of) | zf;
        4'h2: e.cnd = sf ^ of;
        4'h3: e.cnd = zf;
        4'h4: e.cnd = !zf;
        4'h5: e.cnd = !(sf ^ of);
        4'h6: e.cnd = !(sf ^ of) && !zf;
        default: e.cnd = 1'b0;
      endcase
    end
    return e;
  endfunction

  // Monitor: pops the scoreboard whenever a result transfer is about to occur.
  exp_t mon_e;
  int   n_out = 0;
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 64'(exp_q.size()), 64'd1);
      end else begin
        mon_e = exp_q.pop_front();
        if (!mon_e.err) check($sformatf("valE[%0d]", n_out), out_valE, mon_e.val_e);
        check($sformatf("err[%0d]", n_out), 64'(out_err), 64'(mon_e.err));
        check($sformatf("cnd[%0d]", n_out), 64'(out_cnd), 64'(mon_e.cnd));
        check($sformatf("cc[%0d]",  n_out), 64'(out_cc),  64'(mon_e.cc));
      end
      n_out++;
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rand_mode ? ($urandom_range(3) != 0) : force_ready;
    end
  end

  // Drives a request, waits for acceptance and pushes the expected result.
  // Called and returns at posedge+1; with do_lat it ends at the DONE negedge.
  task automatic start_req(input logic [3:0] icode, input logic [3:0] ifun,
                           input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] c, input logic inh, input bit do_lat);
    exp_t e;
    int   t;
    in_icode      = icode;
    in_ifun       = ifun;
    in_valA       = a;
    in_valB       = b;
    in_valC       = c;
    in_cc_inhibit = inh;
    in_valid      = 1'b1;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("accept_timeout", 64'(in_ready), 64'd1);
    e        = ref_model(icode, ifun, a, b, c, inh, model_cc);
    prev_cc  = model_cc;
    model_cc = e.cc;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (do_lat) begin
      @(negedge clk);
      check("lat_exec_valid", 64'(out_valid), 64'd0);
      @(negedge clk);
      check("lat_done_valid", 64'(out_valid), 64'd1);
    end
  endtask

  // Called at a DONE negedge; waits for the result transfer, returns at posedge+1.
  task automatic finish_req();
    int t;
    t = 0;
    while (!(out_valid && out_ready) && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!(out_valid && out_ready)) check("complete_timeout", 64'(out_valid && out_ready), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic [3:0] icode, input logic [3:0] ifun,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] c, input logic inh);
    start_req(icode, ifun, a, b, c, inh, 1'b1);
    finish_req();
  endtask

  function automatic logic [63:0] rand64();
    case ($urandom_range(5))
      0:       return 64'd0;
      1:       return 64'hFFFF_FFFF_FFFF_FFFF;
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'h7FFF_FFFF_FFFF_FFFF;
      4:       return 64'($urandom_range(15));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    rst_n = 1'b0;  in_valid = 1'b0;  flush = 1'b0;
    in_icode = '0; in_ifun = '0; in_valA = '0; in_valB = '0; in_valC = '0;
    in_cc_inhibit = 1'b0;
    model_cc = 3'b100;
    prev_cc  = 3'b100;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_err",   64'(out_err),   64'd0);
    check("rst_out_cnd",   64'(out_cnd),   64'd0);
    check("rst_out_valE",  out_valE,       64'd0);
    check("rst_out_cc",    64'(out_cc),    64'h4);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    @(posedge clk);
    #1;

    // Signed overflow on add; check explicit values before the transfer.
    start_req(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b0, 1'b1);
    check("ovf_valE", out_valE, 64'h8000_0000_0000_0000);
    check("ovf_cc",   64'(out_cc), 64'h3);
    finish_req();

    do_req(4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 1'b0);
    check("sub_zero_cc", 64'(out_cc), 64'h4);
    start_req(4'h7, 4'h3, 64'd0, 64'd0, 64'h1234, 1'b0, 1'b1);
    check("je_cnd", 64'(out_cnd), 64'd1);
    finish_req();
    do_req(4'h5, 4'h0, 64'd0, 64'h100, 64'h10, 1'b0);
    start_req(4'hA, 4'h0, 64'd0, 64'h200, 64'd0, 1'b0, 1'b1);
    check("push_valE", out_valE, 64'h1F8);
    finish_req();

    // Backpressure: result must hold and no new request may be taken.
    force_ready = 1'b0;
    e = ref_model(4'h6, 4'h3, 64'hF0F0, 64'h0FF0, 64'd0, 1'b0, model_cc);
    start_req(4'h6, 4'h3, 64'hF0F0, 64'h0FF0, 64'd0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check("bp_valid",    64'(out_valid), 64'd1);
      check("bp_valE",     out_valE,       e.val_e);
      check("bp_in_ready", 64'(in_ready),  64'd0);
      @(negedge clk);
    end
    force_ready = 1'b1;
    finish_req();

    // Flush in EXEC drops the operation and leaves CC untouched.
    start_req(4'h6, 4'h1, 64'd1, 64'd0, 64'd0, 1'b0, 1'b0);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    void'(exp_q.pop_back());
    model_cc = prev_cc;
    @(negedge clk);
    check("flush_in_ready",  64'(in_ready),  64'd1);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_cc",        64'(out_cc),    64'(model_cc));
    @(negedge clk);
    check("flush_no_valid",  64'(out_valid), 64'd0);
    @(posedge clk);
    #1;

    // Flush overrides a handshake in IDLE.
    in_icode = 4'h6; in_ifun = 4'h0; in_valA = 64'd3; in_valB = 64'd4; in_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush_idle_not_accepted", 64'(in_ready), 64'd1);
    @(negedge clk);
    check("flush_idle_no_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;

    do_req(4'hC, 4'h0, 64'd1, 64'd2, 64'd3, 1'b0);
    do_req(4'h6, 4'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1);
    do_req(4'h6, 4'h5, 64'd1, 64'd2, 64'd0, 1'b0);
    do_req(4'h2, 4'h7, 64'd9, 64'd0, 64'd0, 1'b0);

    // Reset while DONE is stalled.
    force_ready = 1'b0;
    start_req(4'h6, 4'h0, 64'd1, 64'h8000_0000_0000_0000, 64'd0, 1'b0, 1'b1);
    rst_n = 1'b0;
    void'(exp_q.pop_back());
    model_cc = 3'b100;
    @(negedge clk);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_cc",        64'(out_cc),    64'h4);
    @(posedge clk);
    #1 rst_n = 1'b1;
    force_ready = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    rand_mode = 1'b1;
    for (int n = 0; n < 200; n++) begin
      logic [3:0] ic, fn;
      ic = 4'($urandom_range(15));
      fn = ($urandom_range(7) == 0) ? 4'($urandom_range(15)) : 4'($urandom_range(7));
      start_req(ic, fn, rand64(), rand64(), rand64(), ($urandom_range(7) == 0), 1'b1);
      finish_req();
    end
    rand_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
